// File: rtl/rom_arbiter.sv
// rom_arbiter: two-requester arbiter in front of a ROM with a 1-cycle
// synchronous read. Each read takes three cycles (IDLE -> READ -> DATA).
// The grant is a one-cycle pulse, and read data returns with a one-cycle
// rvalid pulse to the winning requester.
// Optional feature macro: ROM_ARB_RR_EN. When defined, contention is resolved
// round-robin. Otherwise requester 0 has fixed priority.
module rom_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [1:0]            req_i,
  input  logic [ADDR_WIDTH-1:0] addr0_i,
  input  logic [ADDR_WIDTH-1:0] addr1_i,
  output logic [1:0]            gnt_o,
  output logic [1:0]            rvalid_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  busy_o,
  output logic [ADDR_WIDTH-1:0] rom_addr_o,
  input  logic [DATA_WIDTH-1:0] rom_data_i
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] READ = 2'd1;
  localparam logic [1:0] DATA = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [1:0]            gnt_q, gnt_d;
  logic [1:0]            rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
  logic                  win_q, win_d;    // requester owning the read in flight
  logic                  win_sel;         // arbitration result for this edge

`ifdef ROM_ARB_RR_EN
  logic                  ptr_q, ptr_d;    // last-granted requester

  // Round-robin: on contention the requester not granted last time wins.
  always_comb begin
    win_sel = (&req_i) ? ~ptr_q : req_i[1];
  end
`else
  // Fixed priority: requester 0 wins whenever it asks.
  always_comb begin
    win_sel = ~req_i[0];
  end
`endif

  // Next-state logic. Requests are only looked at in IDLE.
  always_comb begin
    state_d    = state_q;
    gnt_d      = 2'b00;
    rvalid_d   = 2'b00;
    rdata_d    = rdata_q;
    rom_addr_d = rom_addr_q;
    win_d      = win_q;
`ifdef ROM_ARB_RR_EN
    ptr_d      = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (|req_i) begin
          state_d    = READ;
          win_d      = win_sel;
          gnt_d      = win_sel ? 2'b10 : 2'b01;
          rom_addr_d = win_sel ? addr1_i : addr0_i;
`ifdef ROM_ARB_RR_EN
          ptr_d      = win_sel;
`endif
        end
      end
      // The ROM latches rom_addr on this edge. There is nothing else to do.
      READ: state_d = DATA;
      DATA: begin
        state_d  = IDLE;
        rdata_d  = rom_data_i;
        rvalid_d = win_q ? 2'b10 : 2'b01;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      gnt_q      <= 2'b00;
      rvalid_q   <= 2'b00;
      rdata_q    <= '0;
      rom_addr_q <= '0;
      win_q      <= 1'b0;
`ifdef ROM_ARB_RR_EN
      ptr_q      <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rom_addr_q <= rom_addr_d;
      win_q      <= win_d;
`ifdef ROM_ARB_RR_EN
      ptr_q      <= ptr_d;
`endif
    end
  end

  assign gnt_o      = gnt_q;
  assign rvalid_o   = rvalid_q;
  assign rdata_o    = rdata_q;
  assign rom_addr_o = rom_addr_q;
  assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter. It models the external ROM, applies a vector table
// plus directed and random sequences, and compares every cycle against a
// transaction-level reference model.
module tb_rom_arbiter;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] req = 2'b00;
  logic [3:0] addr0 = 4'h0, addr1 = 4'h0;
  logic [1:0] gnt, rvalid;
  logic [7:0] rdata, rom_data;
  logic       busy;
  logic [3:0] rom_addr;
  logic [7:0] mem [16];

  int total = 0, bad = 0;

  rom_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .req_i(req), .addr0_i(addr0), .addr1_i(addr1),
    .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata), .busy_o(busy),
    .rom_addr_o(rom_addr), .rom_data_i(rom_data)
  );

  always #5 clk = ~clk;

  // ROM with a 1-cycle synchronous read.
  always @(posedge clk) rom_data <= mem[rom_addr];

  // Reference model. Each grant at edge t reserves edges t..t+2. The data for
  // that grant comes back after edge t+2, and the next request is sampled at
  // edge t+3 or later.
  int         cyc = 0, free_at = 0, rv_at = -1, busy_end = 0;
  logic [1:0] rv_who = 2'b00, e_gnt = 2'b00, e_rv = 2'b00;
  logic [3:0] rv_addr = 4'h0, e_raddr = 4'h0;
  logic [7:0] e_rdata = 8'h00;
  bit         last = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input logic r, input logic [1:0] rq, input logic [3:0] a0, input logic [3:0] a1);
    bit w;
    rst_n = r; req = rq; addr0 = a0; addr1 = a1;
    @(posedge clk);
    cyc++;
    e_gnt = 2'b00; e_rv = 2'b00;
    if (!r) begin
      free_at = cyc + 1; rv_at = -1; busy_end = cyc;
      e_raddr = 4'h0; e_rdata = 8'h00; last = 1'b1;
    end else begin
      if (rv_at == cyc) begin
        e_rv = rv_who; e_rdata = mem[rv_addr]; rv_at = -1;
      end
      if (cyc >= free_at && rq != 2'b00) begin
`ifdef ROM_ARB_RR_EN
        w = (rq == 2'b11) ? !last : rq[1];
`else
        w = !rq[0];
`endif
        last = w;
        e_gnt = w ? 2'b10 : 2'b01;
        e_raddr = w ? a1 : a0;
        rv_who = e_gnt; rv_addr = e_raddr;
        rv_at = cyc + 2; free_at = cyc + 3; busy_end = cyc + 2;
      end
    end
    #1;
    chk("gnt", 32'(gnt), 32'(e_gnt));
    chk("rvalid", 32'(rvalid), 32'(e_rv));
    chk("busy", 32'(busy), 32'(cyc < busy_end));
    chk("rom_addr", 32'(rom_addr), 32'(e_raddr));
    chk("rdata", 32'(rdata), 32'(e_rdata));
  endtask

  typedef struct {
    logic       rst_n;
    logic [1:0] req;
    logic [3:0] a0, a1;
    logic [1:0] gnt, rv;
    logic       busy;
  } vec_t;

  function automatic vec_t mk(logic r, logic [1:0] rq, logic [3:0] a0, logic [3:0] a1,
                              logic [1:0] g, logic [1:0] v, logic b);
    vec_t t;
    t.rst_n = r; t.req = rq; t.a0 = a0; t.a1 = a1; t.gnt = g; t.rv = v; t.busy = b;
    return t;
  endfunction

  vec_t tbl [16];

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'(8'hA5 ^ (i * 29));

    // Each row drives the inputs before one edge and gives the outputs
    // expected after that edge.
    // Single read from requester 0, address 3.
    tbl[0]  = mk(1, 2'b01, 4'h3, 4'h0, 2'b01, 2'b00, 1);
    tbl[1]  = mk(1, 2'b00, 4'h0, 4'h0, 2'b00, 2'b00, 1);
    tbl[2]  = mk(1, 2'b00, 4'h0, 4'h0, 2'b00, 2'b01, 0);
    tbl[3]  = mk(1, 2'b00, 4'h0, 4'h0, 2'b00, 2'b00, 0);
    // Reset while in DATA: the read is aborted, then a new request is served.
    tbl[4]  = mk(1, 2'b01, 4'h5, 4'h0, 2'b01, 2'b00, 1);
    tbl[5]  = mk(1, 2'b00, 4'h0, 4'h0, 2'b00, 2'b00, 1);
    tbl[6]  = mk(0, 2'b00, 4'h0, 4'h0, 2'b00, 2'b00, 0);
    tbl[7]  = mk(1, 2'b01, 4'h6, 4'h0, 2'b01, 2'b00, 1);
    tbl[8]  = mk(1, 2'b00, 4'h0, 4'h0, 2'b00, 2'b00, 1);
    tbl[9]  = mk(1, 2'b00, 4'h0, 4'h0, 2'b00, 2'b01, 0);
    // Requester 1 raises req in READ and drops it before IDLE, so it is
    // ignored. Requester 0 raises req in DATA and is granted at the IDLE edge.
    tbl[10] = mk(1, 2'b01, 4'h7, 4'h0, 2'b01, 2'b00, 1);
    tbl[11] = mk(1, 2'b10, 4'h0, 4'h9, 2'b00, 2'b00, 1);
    tbl[12] = mk(1, 2'b01, 4'h8, 4'h0, 2'b00, 2'b01, 0);
    tbl[13] = mk(1, 2'b01, 4'h8, 4'h0, 2'b01, 2'b00, 1);
    tbl[14] = mk(1, 2'b00, 4'h0, 4'h0, 2'b00, 2'b00, 1);
    tbl[15] = mk(1, 2'b00, 4'h0, 4'h0, 2'b00, 2'b01, 0);

    // Reset state.
    step(0, 2'b00, 4'h0, 4'h0);
    step(0, 2'b00, 4'h0, 4'h0);
    chk("rst_all_zero", 32'({gnt, rvalid, busy, rdata, rom_addr}), 32'd0);

    for (int i = 0; i < 16; i++) begin
      step(tbl[i].rst_n, tbl[i].req, tbl[i].a0, tbl[i].a1);
      chk("tbl_gnt", 32'(gnt), 32'(tbl[i].gnt));
      chk("tbl_rvalid", 32'(rvalid), 32'(tbl[i].rv));
      chk("tbl_busy", 32'(busy), 32'(tbl[i].busy));
    end
    chk("tbl_rdata_mem8", 32'(rdata), 32'(mem[8]));

    // Continuous contention after reset. The model gives the policy-specific
    // grant order: alternating in the round-robin build, always requester 0
    // in the fixed-priority build.
    step(0, 2'b00, 4'h0, 4'h0);
    for (int i = 0; i < 12; i++) step(1, 2'b11, 4'h1, 4'h2);
    for (int i = 0; i < 3; i++) step(1, 2'b00, 4'h0, 4'h0);

    // Sweep all addresses through requester 1.
    for (int a = 0; a < 16; a++) begin
      step(1, 2'b10, 4'h0, 4'(a));
      step(1, 2'b00, 4'h0, 4'h0);
      step(1, 2'b00, 4'h0, 4'h0);
      chk("sweep_rdata", 32'(rdata), 32'(mem[a]));
    end

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 39) != 0), 2'($urandom_range(0, 3)),
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
